// File: rtl/sm_mcu_cpu_mult_pkg.sv
// Shared types and op-decoding helpers for the SM_MCU iterative multiply unit.
package sm_mcu_cpu_mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mult_state_e;

    function automatic logic is_signed_a(input mult_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic is_signed_b(input mult_op_e op);
        return (op == OP_MULH);
    endfunction

    function automatic logic returns_high(input mult_op_e op);
        return (op != OP_MUL);
    endfunction

endpackage

// File: rtl/sm_mcu_cpu_mult_if.sv
// Request/response handshake bundle between the A stage and the multiply unit.
interface sm_mcu_cpu_mult_if
    import sm_mcu_cpu_mult_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    mult_op_e          in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/sm_mcu_cpu_mult_slice.sv
// Single unsigned SLICE_W x SLICE_W multiplier; time-shared by the unit for every partial product.
module sm_mcu_cpu_mult_slice #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0]   a,
    input  logic [SLICE_W-1:0]   b,
    output logic [2*SLICE_W-1:0] p
);
    localparam int PP_W = 2 * SLICE_W;

    assign p = PP_W'(a) * PP_W'(b);
endmodule

// File: rtl/sm_mcu_cpu_mult_unit.sv
// Iterative sign-magnitude multiply unit: one slice product per cycle into a 2*DATA_W accumulator.
module sm_mcu_cpu_mult_unit
    import sm_mcu_cpu_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input logic               clk,
    input logic               reset,
    sm_mcu_cpu_mult_if.slave  bus
);
    localparam int N     = DATA_W / SLICE_W;
    localparam int ACC_W = 2 * DATA_W;
    localparam int PP_W  = 2 * SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    mult_state_e       state_q, state_d;
    mult_op_e          op_q;
    logic              neg_q;
    logic [DATA_W-1:0] a_mag_q, b_mag_q;
    logic [DATA_W-1:0] result_q;
    logic [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]  i_q, j_q;

    logic              sign_a_in, sign_b_in;
    logic [DATA_W-1:0] a_mag_in, b_mag_in;
    logic [IDX_W-1:0]  j_last;
    logic              pair_last, mul_last;
    logic [SLICE_W-1:0] a_slice, b_slice;
    logic [PP_W-1:0]   pp;
    logic [ACC_W-1:0]  pp_shifted;
    logic [ACC_W-1:0]  acc_fix;
    logic [DATA_W-1:0] fix_word;

    // Magnitudes are taken as unsigned DATA_W values, so the most negative input maps to 2^(DATA_W-1).
    assign sign_a_in = is_signed_a(bus.in_op) && bus.in_a[DATA_W-1];
    assign sign_b_in = is_signed_b(bus.in_op) && bus.in_b[DATA_W-1];
    assign a_mag_in  = sign_a_in ? -bus.in_a : bus.in_a;
    assign b_mag_in  = sign_b_in ? -bus.in_b : bus.in_b;

    // Low-word ops stop each row at i+j = N-1; higher pairs only touch discarded bits.
    assign j_last    = (op_q == OP_MUL) ? (IDX_MAX - i_q) : IDX_MAX;
    assign pair_last = (j_q == j_last);
    assign mul_last  = pair_last && (i_q == IDX_MAX);

    assign a_slice    = a_mag_q[SLICE_W * 32'(i_q) +: SLICE_W];
    assign b_slice    = b_mag_q[SLICE_W * 32'(j_q) +: SLICE_W];
    assign pp_shifted = ACC_W'(pp) << (SLICE_W * (32'(i_q) + 32'(j_q)));

    sm_mcu_cpu_mult_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a (a_slice),
        .b (b_slice),
        .p (pp)
    );

    assign acc_fix  = neg_q ? -acc_q : acc_q;
    assign fix_word = returns_high(op_q) ? acc_fix[ACC_W-1:DATA_W] : acc_fix[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_MUL;
            ST_MUL:  if (mul_last)      state_d = ST_FIX;
            ST_FIX:                     state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            result_q <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.in_op;
                        neg_q   <= sign_a_in ^ sign_b_in;
                        a_mag_q <= a_mag_in;
                        b_mag_q <= b_mag_in;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_q + pp_shifted;
                    if (pair_last) begin
                        i_q <= i_q + 1'b1;
                        j_q <= '0;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_FIX: result_q <= fix_word;
                default: ;
            endcase
        end
    end

    // Reset is the only non-state term here; in_valid/out_ready never reach these outputs.
    assign bus.in_ready   = (state_q == ST_IDLE) && !reset;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;

endmodule
